serial_add_ctrl: RTL and testbench

Bit-serial adder controller that time-shares a single 1-bit full-adder cell (one `fa_dataflow` instance) across all bit positions of a WIDTH-bit addition. It captures two operands and a carry-in on a start request and steps the full adder once per clock, LSB first. It then presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting datapath and the shared full-adder cell, trading WIDTH cycles of latency for one adder cell.

---
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell stepped LSB first
// across a WIDTH-bit add, finishing with a one-cycle done pulse.

module fa_dataflow (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rs_nx;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             fs;
    logic             fc;
    logic             accept;
    logic             last;

    fa_dataflow u_fa (
        .x (ra[0]),
        .y (rb[0]),
        .z (c),
        .s (fs),
        .c (fc)
    );

    // Sum bits enter at the top and walk down, so the LSB lands at bit 0.
    generate
        if (WIDTH == 1) begin : g_rs1
            assign rs_nx = fs;
        end else begin : g_rsn
            assign rs_nx = {fs, rs[WIDTH-1:1]};
        end
    endgenerate

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            rs  <= '0;
            c   <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            ra  <= a;
            rb  <= b;
            rs  <= '0;
            c   <= ci;
            cnt <= '0;
        end else if (state == RUN) begin
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            rs  <= rs_nx;
            c   <= fc;
            cnt <= cnt + CW'(1);
        end
    end

    // Result registers only move on the final bit, so they hold across later runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else if (last) begin
            s  <= rs_nx;
            co <= fc;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 instance plus a WIDTH=1
// instance for the exhaustive full-adder truth table.

module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       co;

    logic       start1;
    logic       a1;
    logic       b1;
    logic       ci1;
    logic       busy1;
    logic       done1;
    logic       s1;
    logic       co1;

    int n_chk;
    int n_fail;
    logic [8:0] last_res;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .ci    (ci1),
        .busy  (busy1),
        .done  (done1),
        .s     (s1),
        .co    (co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one WIDTH=8 op; p1/p2 are cycles at which a stray start is pulsed.
    task automatic run_op(input string tag, input logic [7:0] ta,
                          input logic [7:0] tb, input logic tci,
                          input logic [8:0] exp, input int p1, input int p2);
        int nb;
        int nd;
        int dat;
        nb  = 0;
        nd  = 0;
        dat = 0;
        @(negedge clk);
        a     = ta;
        b     = tb;
        ci    = tci;
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                dat = k;
            end
            if (k == 5) check({tag, "_hold"}, {23'd0, co, s}, {23'd0, last_res});
            a     = 8'hFF;
            b     = 8'hFF;
            ci    = 1'b1;
            start = (k == p1) || (k == p2);
        end
        start = 1'b0;
        check({tag, "_busy"}, nb, 8);
        check({tag, "_ndone"}, nd, 1);
        check({tag, "_tdone"}, dat, 9);
        check({tag, "_sum"}, {23'd0, co, s}, {23'd0, exp});
        last_res = exp;
    endtask

    task automatic run1(input logic [2:0] v);
        int nb;
        int nd;
        int dat;
        nb  = 0;
        nd  = 0;
        dat = 0;
        @(negedge clk);
        ci1    = v[2];
        a1     = v[1];
        b1     = v[0];
        start1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            a1     = ~v[1];
            b1     = ~v[0];
            if (busy1) nb++;
            if (done1) begin
                nd++;
                dat = k;
            end
        end
        check($sformatf("w1_%0d_busy", v), nb, 1);
        check($sformatf("w1_%0d_ndone", v), nd, 1);
        check($sformatf("w1_%0d_tdone", v), dat, 2);
        check($sformatf("w1_%0d_sum", v), {30'd0, co1, s1},
              32'(v[2]) + 32'(v[1]) + 32'(v[0]));
    endtask

    initial begin
        int nb;
        int nd;
        int idx;
        logic [7:0] ca [3];
        logic [7:0] cb [3];
        logic       cc [3];
        logic [8:0] ce [3];

        n_chk    = 0;
        n_fail   = 0;
        last_res = '0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        ci       = 1'b0;
        start1   = 1'b0;
        a1       = 1'b0;
        b1       = 1'b0;
        ci1      = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", {23'd0, co, s}, 0);
        rst = 1'b0;
        nb  = 0;
        nd  = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        check("idle_busy", nb, 0);
        check("idle_done", nd, 0);
        check("idle_sum", {23'd0, co, s}, 0);

        run_op("add3c42", 8'h3C, 8'h42, 1'b0, 9'h07E, -1, -1);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 9'h100, -1, -1);
        run_op("adda55a", 8'hA5, 8'h5A, 1'b1, 9'h100, -1, -1);
        run_op("ignore", 8'h10, 8'h20, 1'b0, 9'h030, 3, 9);

        // Abort mid-run: reset lands during cycle 4 of RUN.
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        ci    = 1'b1;
        start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sum", {23'd0, co, s}, 0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_done", nd, 0);
        last_res = '0;
        run_op("fresh", 8'h12, 8'h34, 1'b1, 9'h047, -1, -1);

        // Start held high: accepts every 10 cycles, operands swapped at done.
        ca[0] = 8'h01; cb[0] = 8'h02; cc[0] = 1'b0; ce[0] = 9'h003;
        ca[1] = 8'h80; cb[1] = 8'h80; cc[1] = 1'b1; ce[1] = 9'h101;
        ca[2] = 8'h7F; cb[2] = 8'h7F; cc[2] = 1'b1; ce[2] = 9'h0FF;
        @(negedge clk);
        a     = ca[0];
        b     = cb[0];
        ci    = cc[0];
        start = 1'b1;
        idx   = 0;
        for (int k = 1; k <= 40 && idx < 3; k++) begin
            @(negedge clk);
            if (done) begin
                check($sformatf("cont%0d_t", idx), k, 9 + 10 * idx);
                check($sformatf("cont%0d_sum", idx), {23'd0, co, s},
                      {23'd0, ce[idx]});
                idx++;
                if (idx < 3) begin
                    a  = ca[idx];
                    b  = cb[idx];
                    ci = cc[idx];
                end
            end
        end
        start = 1'b0;
        check("cont_count", idx, 3);

        for (int v = 0; v < 8; v++) begin
            run1(3'(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
